// File: rtl/word_packer_if.sv
// Beat-in / word-out handshake bundle for word_packer.
// The slave modport is the packer side; the master modport is the producer/consumer side.
interface word_packer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO + 1);

  logic [IN_W-1:0]  data_in;
  logic             valid;
  logic             flush;
  logic             in_ready;
  logic [OUT_W-1:0] data_out;
  logic             valid_out;
  logic             out_ready;
  logic [CW-1:0]    lanes_out;

  modport master (
    output data_in, valid, flush, out_ready,
    input  in_ready, data_out, valid_out, lanes_out
  );

  modport slave (
    input  data_in, valid, flush, out_ready,
    output in_ready, data_out, valid_out, lanes_out
  );
endinterface

// File: rtl/word_packer.sv
// Packs RATIO narrow input beats into one wide registered output word.
// A flush emits a partially filled word, with the unfilled lanes zeroed.
module word_packer #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 1
) (
  input logic           clk_4f,
  input logic           reset,
  word_packer_if.slave  bus
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] buf_q, buf_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [CW-1:0]    lanes_q, lanes_d;
  logic             valid_q, valid_d;

  logic             inReady;
  logic             beatAcc;
  logic             flushAcc;
  logic             xfer;
  logic             complete;
  logic             emitPartial;
  logic [CW-1:0]    cntAfter;
  logic [OUT_W-1:0] bufWithBeat;

  assign inReady  = !valid_q || bus.out_ready;
  assign beatAcc  = bus.valid && inReady;
  assign flushAcc = bus.flush && inReady;
  assign xfer     = valid_q && bus.out_ready;

  assign cntAfter    = cnt_q + {{(CW-1){1'b0}}, beatAcc};
  assign complete    = beatAcc && (cnt_q == CW'(RATIO - 1));
  assign emitPartial = flushAcc && !complete && (cntAfter != '0);

  // Accumulation buffer as it would look with this cycle's beat dropped into lane cnt_q.
  always_comb begin
    bufWithBeat = buf_q;
    if (beatAcc) begin
      if (MSB_FIRST != 0) begin
        bufWithBeat[OUT_W - IN_W - int'(cnt_q) * IN_W +: IN_W] = bus.data_in;
      end else begin
        bufWithBeat[int'(cnt_q) * IN_W +: IN_W] = bus.data_in;
      end
    end
  end

  always_comb begin
    cnt_d   = cntAfter;
    buf_d   = bufWithBeat;
    data_d  = data_q;
    lanes_d = lanes_q;
    valid_d = valid_q;
    if (xfer) begin
      valid_d = 1'b0;
    end
    // A new word may load on the same edge the previous one is consumed.
    if (complete || emitPartial) begin
      data_d  = bufWithBeat;
      lanes_d = cntAfter;
      valid_d = 1'b1;
      cnt_d   = '0;
      buf_d   = '0;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      cnt_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      lanes_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      lanes_q <= lanes_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.lanes_out = lanes_q;
endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 Parameter IN_W, default 8, width of one input beat in bits.
REQ-002 Parameter RATIO, default 4, number of input beats per output word (legal 2..16).
REQ-003 Parameter MSB_FIRST, default 1: 1 = first beat lands in the most significant lane; 0 = first beat lands in the least significant lane.
REQ-004 Local OUT_W = IN_W*RATIO; CW = $clog2(RATIO+1).
REQ-005 clk_4f  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data_in  input  IN_W  input beat.
REQ-008 valid  input  1  data_in qualifier.
REQ-009 flush  input  1  request to emit any partially filled word.
REQ-010 in_ready  output  1  block can accept a beat or flush this cycle.
REQ-011 data_out  output  OUT_W  packed word, registered.
REQ-012 valid_out  output  1  data_out/lanes_out hold a word.
REQ-013 out_ready  input  1  downstream consumes the word.
REQ-014 lanes_out  output  CW  number of filled lanes in data_out (RATIO for full words, 1..RATIO-1 for flushed words).

Function
REQ-015 Beat accepted iff valid && in_ready; flush accepted iff flush && in_ready; output transfer iff valid_out && out_ready.
REQ-016 in_ready SHALL equal !valid_out || out_ready (combinational); no beat or flush is accepted while a word is held and stalled.
REQ-017 Internal lane counter cnt (0..RATIO-1) and accumulation buffer; each accepted beat is written into lane cnt and cnt increments.
REQ-018 Lane placement: MSB_FIRST=1 -> beat k occupies bits [OUT_W-1-k*IN_W -: IN_W]; MSB_FIRST=0 -> bits [k*IN_W +: IN_W].
REQ-019 Beat accepted with cnt==RATIO-1 completes the word: on the next edge data_out = full buffer including that beat, lanes_out = RATIO, valid_out = 1, cnt wraps to 0, buffer clears.
REQ-020 Latency: valid_out rises exactly one clk_4f cycle after the edge accepting the last beat.
REQ-021 valid low mid-word SHALL hold cnt and buffer indefinitely; no data is lost or padded on gaps.
REQ-022 Accepted flush with cnt>0 (after any beat accepted the same cycle) SHALL emit the partial word: unfilled lanes zero, lanes_out = filled count, cnt -> 0.
REQ-023 Accepted flush with cnt==0 and no beat that cycle SHALL produce no output; flush coinciding with a word-completing beat emits only that full word (lanes_out = RATIO).
REQ-024 Flush together with a non-completing beat includes that beat in the partial word.
REQ-025 valid_out, data_out, lanes_out SHALL remain stable while valid_out && !out_ready.
REQ-026 valid_out falls on the edge after a transfer unless a new word is loaded on that same edge (back-to-back words, zero bubble).
REQ-027 Sustained throughput: one beat per cycle with out_ready held high, no stalls.
REQ-028 flush and valid when in_ready is low SHALL have no effect; sender must hold them.

Reset
REQ-029 reset high at an edge: data_out = 0, valid_out = 0, lanes_out = 0, cnt = 0, buffer = 0; in_ready therefore 1.
REQ-030 reset overrides all other inputs in the same cycle; a partially filled word is discarded, not flushed.

Verification
REQ-031 Defaults, out_ready=1, beats 0x11,0x22,0x33,0x44 consecutive -> one cycle later data_out=0x11223344, lanes_out=4, valid_out=1 for one cycle.
REQ-032 MSB_FIRST=0, same beats -> data_out=0x44332211.
REQ-033 Beats 0xAA,0xBB, valid low 5 cycles, then 0xCC,0xDD -> single word 0xAABBCCDD, no output during gap.
REQ-034 Beats 0x01,0x02,0x03 then flush -> data_out=0x01020300, lanes_out=3; flush with empty buffer -> no valid_out.
REQ-035 out_ready low with word 0x11223344 held, continuous valid -> in_ready=0, data_out stable, no beat lost; raise out_ready -> next 8 beats yield two words back-to-back.
REQ-036 reset asserted after 2 beats, then 4 beats 0x55..0x88 -> first output 0x55667788, earlier beats absent.
